pwm_timer_ctrl: RTL

Sequencing controller for the PWM main counter. It owns the counter's enable and auto-reload preload input, and buffers host ARR/repetition writes so they take effect only at update events. It divides counter overflows into update events through a repetition counter, and supports one-pulse mode and software-forced updates. It sits between the timer register file and the main counter, in the prescaler clock domain.

---
 rtl/pwm_timer_ctrl_if.sv | 42 ++++
 rtl/pwm_timer_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pwm_timer_ctrl_if.sv
// pwm_timer_ctrl_if
//   Bus between the timer register file / main counter and pwm_timer_ctrl.
//   slave  : the controller (consumes config/commands, drives status).
//   master : the register file / counter side (drives config/commands).
// Signals:
//   cfg_wr_i, cfg_arr_i, cfg_rcr_i, cfg_opm_i : config write and its payload
//   start_i, stop_i, ug_i, uif_clr_i          : command pulses
//   overflow_i                                : overflow pulse from the counter
//   cnt_en_o, arr_preload_o                   : counter enable and ARR preload
//   uev_o, uif_o, busy_o, rep_cnt_o           : update event and status
interface pwm_timer_ctrl_if #(
  parameter int CNT_WIDTH = 16,
  parameter int RCR_WIDTH = 8
);
  logic                 cfg_wr_i;
  logic [CNT_WIDTH-1:0] cfg_arr_i;
  logic [RCR_WIDTH-1:0] cfg_rcr_i;
  logic                 cfg_opm_i;
  logic                 start_i;
  logic                 stop_i;
  logic                 ug_i;
  logic                 uif_clr_i;
  logic                 overflow_i;
  logic                 cnt_en_o;
  logic [CNT_WIDTH-1:0] arr_preload_o;
  logic                 uev_o;
  logic                 uif_o;
  logic                 busy_o;
  logic [RCR_WIDTH-1:0] rep_cnt_o;

  modport master (
    output cfg_wr_i, cfg_arr_i, cfg_rcr_i, cfg_opm_i,
    output start_i, stop_i, ug_i, uif_clr_i, overflow_i,
    input  cnt_en_o, arr_preload_o, uev_o, uif_o, busy_o, rep_cnt_o
  );

  modport slave (
    input  cfg_wr_i, cfg_arr_i, cfg_rcr_i, cfg_opm_i,
    input  start_i, stop_i, ug_i, uif_clr_i, overflow_i,
    output cnt_en_o, arr_preload_o, uev_o, uif_o, busy_o, rep_cnt_o
  );
endinterface

// File: rtl/pwm_timer_ctrl.sv
// pwm_timer_ctrl
//   Sequencing controller for the PWM main counter. Owns the counter enable
//   and ARR preload, buffers host ARR/RCR writes until update events, divides
//   overflows into update events with a repetition down-counter, and supports
//   one-pulse mode and software-forced updates.
// Ports:
//   clk_psc_i : prescaler clock
//   rst_n_i   : asynchronous active-low reset
//   bus       : pwm_timer_ctrl_if.slave (config, commands, overflow in;
//               cnt_en/arr_preload/uev/uif/busy/rep_cnt out)
module pwm_timer_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int RCR_WIDTH = 8
) (
  input  logic                clk_psc_i,
  input  logic                rst_n_i,
  pwm_timer_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_UPD  = 2'd2
  } state_e;

  state_e               state_q,       state_d;
  logic [CNT_WIDTH-1:0] arr_stage_q,   arr_stage_d;
  logic [RCR_WIDTH-1:0] rcr_stage_q,   rcr_stage_d;
  logic                 opm_q,         opm_d;
  logic [CNT_WIDTH-1:0] arr_preload_q, arr_preload_d;
  logic [RCR_WIDTH-1:0] rep_cnt_q,     rep_cnt_d;
  logic                 uev_q,         uev_d;
  logic                 uif_q,         uif_d;

  always_comb begin
    state_d       = state_q;
    rep_cnt_d     = rep_cnt_q;
    uev_d         = 1'b0;
    arr_stage_d   = arr_stage_q;
    rcr_stage_d   = rcr_stage_q;
    opm_d         = opm_q;
    arr_preload_d = arr_preload_q;

    // Staging registers accept host writes in every state.
    if (bus.cfg_wr_i) begin
      arr_stage_d = bus.cfg_arr_i;
      rcr_stage_d = bus.cfg_rcr_i;
      opm_d       = bus.cfg_opm_i;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d   = ST_RUN;
          rep_cnt_d = rcr_stage_q;
        end
      end
      ST_RUN: begin
        if (bus.stop_i) begin
          state_d = ST_IDLE;
        end else if (bus.ug_i) begin
          // uev and the reload are registered on UPD entry so they are
          // visible during the single UPD cycle.
          state_d   = ST_UPD;
          rep_cnt_d = rcr_stage_q;
          uev_d     = 1'b1;
        end else if (bus.overflow_i) begin
          if (rep_cnt_q != '0) begin
            rep_cnt_d = rep_cnt_q - 1'b1;
          end else begin
            uev_d     = 1'b1;
            rep_cnt_d = rcr_stage_q;
            if (opm_q) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_UPD: begin
        // uev was already issued on entry, so stop here still yields a pulse.
        state_d = bus.stop_i ? ST_IDLE : ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Preload tracks the staging value while idle or on the last repetition,
    // so the counter shadow picks it up at the coming overflow.
    if (state_q == ST_IDLE || rep_cnt_q == '0) begin
      arr_preload_d = arr_stage_q;
    end
    if (state_q == ST_RUN && state_d == ST_UPD) begin
      arr_preload_d = arr_stage_q;
    end

    // Flag is set from the registered uev so a clear in the same cycle as
    // the visible pulse loses.
    uif_d = uev_q | (uif_q & ~bus.uif_clr_i);
  end

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      arr_stage_q   <= '0;
      rcr_stage_q   <= '0;
      opm_q         <= 1'b0;
      arr_preload_q <= '0;
      rep_cnt_q     <= '0;
      uev_q         <= 1'b0;
      uif_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      arr_stage_q   <= arr_stage_d;
      rcr_stage_q   <= rcr_stage_d;
      opm_q         <= opm_d;
      arr_preload_q <= arr_preload_d;
      rep_cnt_q     <= rep_cnt_d;
      uev_q         <= uev_d;
      uif_q         <= uif_d;
    end
  end

  assign bus.cnt_en_o      = (state_q == ST_RUN);
  assign bus.busy_o        = (state_q != ST_IDLE);
  assign bus.arr_preload_o = arr_preload_q;
  assign bus.uev_o         = uev_q;
  assign bus.uif_o         = uif_q;
  assign bus.rep_cnt_o     = rep_cnt_q;

endmodule
